// File: rtl/pxs_player_ctrl.sv
// Paddle player stage: moves a paddle once per frame from synchronised buttons and overlays it on the RGB stream.
// Build option: define PXS_PLAYER_ACCEL_EN to enable the per-frame speed ramp (SPEED_MIN up to SPEED_MAX).
module pxs_player_ctrl #(
    parameter int unsigned ORIENT     = 0,
    parameter int unsigned POS_OFFSET = 100,
    parameter int unsigned SIZE       = 80,
    parameter int unsigned THICK      = 10,
    parameter int unsigned AXIS_LEN   = 480,
    parameter int unsigned INIT_POS   = 200,
    parameter int unsigned SPEED_MIN  = 2,
    parameter int unsigned SPEED_MAX  = 8,
    parameter logic [2:0]  COLOR      = 3'b111,
    localparam int unsigned STR_W     = 26,
    localparam int unsigned POS_W     = 10
) (
    input  logic             px_clk,
    input  logic             rst_n,
    input  logic [STR_W-1:0] RGBStr_i,
    input  logic             btn_up,
    input  logic             btn_down,
    output logic [STR_W-1:0] RGBStr_o,
    output logic [POS_W-1:0] pos,
    output logic             collide,
    output logic             frame_tick
);
    localparam int unsigned AW       = 11;
    localparam int unsigned MAX_POS  = AXIS_LEN - SIZE;
    localparam int unsigned STEP_MIN = (SPEED_MIN > SPEED_MAX) ? SPEED_MAX : SPEED_MIN;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [POS_W-1:0]   step_c;
    logic signed [AW-1:0] diff_c;
    logic [AW-1:0]      sum_c;
`ifdef PXS_PLAYER_ACCEL_EN
    logic [POS_W-1:0]   speed_q, speed_d;
`endif

    logic               up_s1_q, up_s2_q, dn_s1_q, dn_s2_q;
    logic               vs_q;
    logic               hit_acc_q;
    logic               collide_q;
    logic               frame_tick_q;
    logic [STR_W-1:0]   rgb_str_q;

    logic               tick_c, up_only_c, dn_only_c;
    logic [POS_W-1:0]   xc_c, yc_c, mv_c, fx_c;
    logic               inside_c, hit_c;

    assign tick_c    = RGBStr_i[1] & ~vs_q;
    assign up_only_c = up_s2_q & ~dn_s2_q;
    assign dn_only_c = dn_s2_q & ~up_s2_q;

    // Hit test: moving-axis coordinate against pos, fixed-axis coordinate against the offset
    assign xc_c = RGBStr_i[22:13];
    assign yc_c = RGBStr_i[12:3];
    assign mv_c = (ORIENT == 0) ? yc_c : xc_c;
    assign fx_c = (ORIENT == 0) ? xc_c : yc_c;

    assign inside_c = RGBStr_i[0]
                   && (AW'(mv_c) >= AW'(pos_q))
                   && (AW'(mv_c) <= AW'(pos_q) + AW'(SIZE - 1))
                   && (AW'(fx_c) >= AW'(POS_OFFSET))
                   && (AW'(fx_c) <= AW'(POS_OFFSET + THICK - 1));
    assign hit_c = inside_c & (|RGBStr_i[25:23]);

    // Movement FSM: direction, step and clamped position, all evaluated only on the frame tick
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        step_c  = POS_W'(STEP_MIN);
        diff_c  = '0;
        sum_c   = '0;
`ifdef PXS_PLAYER_ACCEL_EN
        speed_d = speed_q;
`endif
        if (tick_c) begin
            if (up_only_c) begin
                state_d = UP;
            end else if (dn_only_c) begin
                state_d = DOWN;
            end else begin
                state_d = IDLE;
            end
`ifdef PXS_PLAYER_ACCEL_EN
            // Continuing in the same direction uses the ramped speed; a fresh press starts slow
            if ((state_d != IDLE) && (state_d == state_q)) begin
                step_c = speed_q;
            end
            if (state_d == IDLE) begin
                speed_d = POS_W'(STEP_MIN);
            end else if (step_c >= POS_W'(SPEED_MAX)) begin
                speed_d = POS_W'(SPEED_MAX);
            end else begin
                speed_d = step_c + POS_W'(1);
            end
`endif
            diff_c = $signed({1'b0, pos_q}) - $signed({1'b0, step_c});
            sum_c  = {1'b0, pos_q} + {1'b0, step_c};
            if (state_d == UP) begin
                pos_d = diff_c[AW-1] ? '0 : diff_c[POS_W-1:0];
            end else if (state_d == DOWN) begin
                pos_d = (sum_c > AW'(MAX_POS)) ? POS_W'(MAX_POS) : sum_c[POS_W-1:0];
            end
        end
    end

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pos_q   <= POS_W'(INIT_POS);
`ifdef PXS_PLAYER_ACCEL_EN
            speed_q <= POS_W'(STEP_MIN);
`endif
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
`ifdef PXS_PLAYER_ACCEL_EN
            speed_q <= speed_d;
`endif
        end
    end

    // Synchronisers, frame edge detect, drawing and collision accumulation
    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            up_s1_q      <= 1'b0;
            up_s2_q      <= 1'b0;
            dn_s1_q      <= 1'b0;
            dn_s2_q      <= 1'b0;
            vs_q         <= 1'b0;
            hit_acc_q    <= 1'b0;
            collide_q    <= 1'b0;
            frame_tick_q <= 1'b0;
            rgb_str_q    <= '0;
        end else begin
            up_s1_q      <= btn_up;
            up_s2_q      <= up_s1_q;
            dn_s1_q      <= btn_down;
            dn_s2_q      <= dn_s1_q;
            vs_q         <= RGBStr_i[1];
            frame_tick_q <= tick_c;
            rgb_str_q    <= {(inside_c ? COLOR : RGBStr_i[25:23]), RGBStr_i[22:0]};
            if (tick_c) begin
                collide_q <= hit_acc_q;
                hit_acc_q <= hit_c;
            end else if (hit_c) begin
                hit_acc_q <= 1'b1;
            end
        end
    end

    assign RGBStr_o   = rgb_str_q;
    assign pos        = pos_q;
    assign collide    = collide_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_pxs_player_ctrl.sv
// Testbench for pxs_player_ctrl: vector tables, directed corner sequences and a randomized frame-level model.
module tb_pxs_player_ctrl;

`ifdef PXS_PLAYER_ACCEL_EN
    localparam bit ACCEL = 1'b1;
`else
    localparam bit ACCEL = 1'b0;
`endif
    localparam int MAXP = 400;

    logic        px_clk = 1'b0;
    logic        rst_n;
    logic [25:0] RGBStr_i;
    logic        btn_up, btn_down;
    logic [25:0] RGBStr_o, rgb1;
    logic [9:0]  pos, pos1;
    logic        collide, collide1;
    logic        frame_tick, tick1;

    always #5 px_clk = ~px_clk;

    pxs_player_ctrl u_dut (
        .px_clk(px_clk), .rst_n(rst_n), .RGBStr_i(RGBStr_i),
        .btn_up(btn_up), .btn_down(btn_down),
        .RGBStr_o(RGBStr_o), .pos(pos), .collide(collide), .frame_tick(frame_tick)
    );

    pxs_player_ctrl #(.ORIENT(1), .AXIS_LEN(640), .POS_OFFSET(460), .INIT_POS(300)) u_dut1 (
        .px_clk(px_clk), .rst_n(rst_n), .RGBStr_i(RGBStr_i),
        .btn_up(btn_up), .btn_down(btn_down),
        .RGBStr_o(rgb1), .pos(pos1), .collide(collide1), .frame_tick(tick1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state (frame-level view of the paddle)
    int m_pos, m_dir, m_run;
    bit m_vs, m_acc, m_collide;

    typedef struct {
        logic [25:0] px;
        logic [2:0]  rgb;
    } vec_t;
    vec_t t0[10];
    vec_t t1[6];
    int ramp[4];
    int p0, p1;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [25:0] mk(input int x, input int y, input int rgb, input bit act, input bit vs);
        logic [2:0] r;
        logic [9:0] xx, yy;
        r  = 3'(rgb);
        xx = 10'(x);
        yy = 10'(y);
        return {r, xx, yy, 1'b0, vs, act};
    endfunction

    function automatic bit in0(input int p, input logic [25:0] s);
        int x, y;
        x = int'(s[22:13]);
        y = int'(s[12:3]);
        return s[0] && (y >= p) && (y <= p + 79) && (x >= 100) && (x <= 109);
    endfunction

    task automatic model_move();
        int d, st;
        d = (btn_up && !btn_down) ? -1 : ((btn_down && !btn_up) ? 1 : 0);
        if (d == 0) m_run = 0;
        else if (d == m_dir) m_run++;
        else m_run = 1;
        m_dir = d;
        st = ACCEL ? ((2 + m_run - 1 > 8) ? 8 : 2 + m_run - 1) : 2;
        m_pos = m_pos + d * st;
        if (m_pos < 0) m_pos = 0;
        if (m_pos > MAXP) m_pos = MAXP;
    endtask

    // Apply one pixel, advance the model, and check every output one cycle later
    task automatic drive(input logic [25:0] p);
        bit tk, h, ins;
        logic [25:0] e;
        RGBStr_i = p;
        tk  = p[1] && !m_vs;
        ins = in0(m_pos, p);
        h   = ins && (p[25:23] != 3'd0);
        e   = {(ins ? 3'b111 : p[25:23]), p[22:0]};
        @(posedge px_clk);
        m_vs = p[1];
        if (tk) begin
            m_collide = m_acc;
            m_acc = h;
            model_move();
        end else if (h) begin
            m_acc = 1'b1;
        end
        #1;
        chk("rgb_out", int'(RGBStr_o), int'(e));
        chk("pos", int'(pos), m_pos);
        chk("collide", int'(collide), int'(m_collide));
        chk("frame_tick", int'(frame_tick), int'(tk));
        chk("frame_tick1", int'(tick1), int'(tk));
    endtask

    task automatic idle_px();
        drive(mk(0, 0, 0, 1'b0, 1'b0));
    endtask

    task automatic set_btn(input bit u, input bit d);
        btn_up = u;
        btn_down = d;
        repeat (3) idle_px();
    endtask

    task automatic tick();
        idle_px();
        drive(mk(0, 0, 0, 1'b0, 1'b1));
        idle_px();
    endtask

    // Asynchronous reset: outputs must clear before any clock edge
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_rgb", int'(RGBStr_o), 0);
        chk("rst_pos", int'(pos), 200);
        chk("rst_collide", int'(collide), 0);
        chk("rst_tick", int'(frame_tick), 0);
        chk("rst_pos1", int'(pos1), 300);
        chk("rst_collide1", int'(collide1), 0);
        @(posedge px_clk);
        #1;
        rst_n = 1'b1;
        m_pos = 200; m_dir = 0; m_run = 0;
        m_vs = 1'b0; m_acc = 1'b0; m_collide = 1'b0;
    endtask

    initial begin
        t0[0] = '{mk(105, 200, 0, 1'b1, 1'b0), 3'b111};
        t0[1] = '{mk(105, 199, 0, 1'b1, 1'b0), 3'b000};
        t0[2] = '{mk(105, 279, 2, 1'b1, 1'b0), 3'b111};
        t0[3] = '{mk(105, 280, 2, 1'b1, 1'b0), 3'b010};
        t0[4] = '{mk(100, 250, 0, 1'b1, 1'b0), 3'b111};
        t0[5] = '{mk(109, 250, 3, 1'b1, 1'b0), 3'b111};
        t0[6] = '{mk(110, 250, 5, 1'b1, 1'b0), 3'b101};
        t0[7] = '{mk(99, 250, 1, 1'b1, 1'b0), 3'b001};
        t0[8] = '{mk(105, 250, 0, 1'b0, 1'b0), 3'b000};
        t0[9] = '{mk(105, 250, 6, 1'b0, 1'b0), 3'b110};
        t1[0] = '{mk(300, 460, 0, 1'b1, 1'b0), 3'b111};
        t1[1] = '{mk(380, 460, 0, 1'b1, 1'b0), 3'b000};
        t1[2] = '{mk(379, 469, 4, 1'b1, 1'b0), 3'b111};
        t1[3] = '{mk(300, 470, 4, 1'b1, 1'b0), 3'b100};
        t1[4] = '{mk(299, 465, 1, 1'b1, 1'b0), 3'b001};
        t1[5] = '{mk(350, 465, 0, 1'b0, 1'b0), 3'b000};
        if (ACCEL) begin
            ramp[0] = 202; ramp[1] = 205; ramp[2] = 209; ramp[3] = 214;
        end else begin
            ramp[0] = 202; ramp[1] = 204; ramp[2] = 206; ramp[3] = 208;
        end

        rst_n = 1'b0;
        RGBStr_i = '0;
        btn_up = 1'b0;
        btn_down = 1'b0;
        @(posedge px_clk);
        #1;
        do_reset();

        // Up held with no frame boundaries: position must not move
        btn_up = 1'b1;
        foreach (t0[i]) begin
            drive(t0[i].px);
            chk("tbl0_rgb", int'(RGBStr_o[25:23]), int'(t0[i].rgb));
        end
        foreach (t1[i]) begin
            drive(t1[i].px);
            chk("tbl1_rgb", int'(rgb1[25:23]), int'(t1[i].rgb));
            chk("tbl1_pass", int'(rgb1[22:0]), int'(t1[i].px[22:0]));
        end
        chk("hold_no_tick", int'(pos), 200);

        // Down ramp, release, fresh press
        do_reset();
        set_btn(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ramp", int'(pos), ramp[i]);
        end
        set_btn(1'b0, 1'b0);
        tick();
        chk("release", int'(pos), ramp[3]);
        set_btn(1'b0, 1'b1);
        tick();
        chk("repress", int'(pos), ramp[3] + 2);

        // Both buttons, then direction reversal
        set_btn(1'b1, 1'b1);
        p0 = int'(pos);
        tick();
        tick();
        chk("both_held", int'(pos), p0);
        set_btn(1'b1, 1'b0);
        tick();
        chk("up_one", int'(pos), p0 - 2);
        p1 = int'(pos);
        set_btn(1'b0, 1'b1);
        tick();
        chk("reverse", int'(pos), p1 + 2);

        // Clamp at both ends
        set_btn(1'b1, 1'b0);
        repeat (120) tick();
        chk("clamp_low", int'(pos), 0);
        set_btn(1'b0, 1'b1);
        repeat (210) tick();
        chk("clamp_high", int'(pos), MAXP);

        // Collision reported after the frame, cleared by a clean frame
        do_reset();
        set_btn(1'b0, 1'b0);
        drive(mk(102, 250, 4, 1'b1, 1'b0));
        tick();
        chk("collide_set", int'(collide), 1);
        tick();
        chk("collide_clear", int'(collide), 0);
        // Hit on the tick cycle belongs to the new frame
        drive(mk(105, 250, 4, 1'b1, 1'b1));
        chk("collide_tick_old", int'(collide), 0);
        tick();
        chk("collide_tick_new", int'(collide), 1);

        // Randomized frames against the model, with occasional mid-frame resets
        for (int f = 0; f < 250; f++) begin
            int b, x, y;
            if ((f % 41) == 17) begin
                drive(mk(105, 250, 7, 1'b1, 1'b0));
                do_reset();
            end
            b = int'($urandom_range(0, 3));
            set_btn(b[0], b[1]);
            for (int k = 0; k < 8; k++) begin
                x = int'($urandom_range(95, 115));
                y = int'($urandom_range(0, 479));
                drive(mk(x, y, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0));
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
